fm_envelope: RTL
================

Name: fm_envelope

Overview:
- Per-operator ADSR envelope generator that sits directly upstream of the FM operator and drives its 12-bit attenuation input.
- Advances once per sample on a one-cycle sample_tick, following OPL-style attack, decay, sustain and release.
- Adds total level and outputs attenuation in log-sin units: 0 = loudest, 4095 = silent.

Parameters:
- EG_CNT_BITS, 15: width of the global envelope rate counter; rate masks use bits [EG_CNT_BITS-1:0].

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_tick  in  1  one-clk pulse per audio sample; all envelope updates occur only on this cycle
- key_on  in  1  note gate level; sampled only on sample_tick
- attack_rate  in  4  0 = never, 15 = instant
- decay_rate  in  4  0 = never, 15 = fastest
- sustain_level  in  4  sustain target = {sustain_level, 5'b0}
- release_rate  in  4  0 = never, 15 = fastest
- sustain_hold  in  1  1 = hold at sustain; 0 = keep decaying at release_rate while key held
- total_level  in  6  static attenuation, 0.75 dB per step
- atten  out  12  attenuation to the operator
- eg_state  out  3  current state encoding
- idle  out  1  high when eg_state == IDLE

Behaviour:
- Registers: env[8:0] (0 loudest, 511 silent), state, key_prev, eg_cnt[EG_CNT_BITS-1:0].
- Reset values: env = 511, state = IDLE, key_prev = 0, eg_cnt = 0, atten = 12'hFFF, idle = 1.
- States: IDLE = 0, ATTACK = 1, DECAY = 2, SUSTAIN = 3, RELEASE = 4.
- Rate step enable for rate r:
  - r = 0: never.
  - r = 1..15: step when (eg_cnt & ((1 << (15 - r)) - 1)) == 0, so r = 15 steps every tick and r = 14 every 2nd tick.
- Decay/release increment: r = 15 -> 4; r = 13..14 -> 2; otherwise 1.
- Every sample_tick, evaluate in this order, then eg_cnt <= eg_cnt + 1 (wraps):
  1. Key rising edge (key_on = 1, key_prev = 0):
     - state <= ATTACK; env is not reset.
     - If attack_rate == 15: env <= 0 on the same tick.
     - No other step is applied this tick.
  2. Key falling edge (key_on = 0, key_prev = 1): state <= RELEASE from any state; no step this tick.
  3. Otherwise, by current state:
     - ATTACK: if env == 0, go to DECAY. Else, on step enable (attack_rate 1..14), env <= env - ((env >> 3) + 1), saturating at 0. Reaching 0 goes to DECAY on the next tick.
     - DECAY: if env >= target, env <= target and go to SUSTAIN. Else, on step enable, env <= env + inc, saturating at 511. Crossing target clamps next tick.
     - SUSTAIN: if sustain_hold = 1, hold env. Else step at release_rate, saturating at 511; state stays SUSTAIN until key-off.
     - RELEASE: on step enable, env += inc, saturating at 511. When env == 511 after the update, state <= IDLE on the same tick.
     - IDLE: no change.
  4. key_prev <= key_on.
- Key pulses that begin and end between two ticks are not seen; this is specified behaviour.
- Output path:
  - atten is registered every clk as min(4095, {env, 3'b0} + {total_level, 5'b0}) using 13-bit intermediate arithmetic.
  - Latency: atten reflects a tick's update 2 clk after the sample_tick cycle.
  - eg_state and idle are driven directly from the state register (1 clk after tick).
- Inputs other than key_on may change at any time; each tick uses the current values.
- Sustain target 480 (sustain_level 15) is the maximum.
- An attack started from env = 511 with attack_rate 1..14 reaches 0 by repeated steps: the step is never 0 and saturates at 0.
- Reset mid-operation returns all state to reset values immediately (asynchronous).
- eg_cnt runs regardless of state.

Decomposition:
- Shared package fm_pkg: state encodings, ENV_MAX = 511, ATTEN_MAX = 4095, and width constants for env and atten.
- One sub-module, fm_eg_rate, is combinational: inputs rate and eg_cnt; outputs step_en and inc[2:0]. It is instantiated once and muxed by state.

Test Plan:
- Reset, then ticks with key_on = 0, total_level = 0: atten = 4088 (0xFF8) after the first clk, eg_state = IDLE, idle = 1 throughout.
- Instant attack: attack_rate = 15, key_on = 1, one tick -> env = 0, atten = 0 two clk later. Next tick -> eg_state = DECAY.
- Decay to sustain: from env 0 with decay_rate = 15, sustain_level = 1 (target 32), sustain_hold = 1 -> env climbs 4 per tick. On the tick after env reaches 32, state = SUSTAIN; atten = 256, stable over 100 further ticks.
- Release: from SUSTAIN at env 32, key_on = 0, release_rate = 15 -> RELEASE on that tick. env reaches 511 after 120 further ticks, and state = IDLE on that same tick.
- Slow rate gating: decay_rate = 14 -> env increments by 2 only on ticks where eg_cnt[0] == 0. decay_rate = 0 -> env frozen.
- Total level saturation: env = 511, total_level = 63 -> atten = 4095, not wrapped. Assert reset mid-RELEASE -> env = 511, state IDLE, atten = 0xFFF immediately.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared constants and state encoding for the FM operator envelope generator.
package fm_pkg;

  localparam int unsigned ENV_W   = 9;
  localparam int unsigned ATTEN_W = 12;

  localparam logic [ENV_W-1:0]   ENV_MAX   = 9'd511;
  localparam logic [ATTEN_W-1:0] ATTEN_MAX = 12'd4095;

  typedef enum logic [2:0] {
    EG_IDLE    = 3'd0,
    EG_ATTACK  = 3'd1,
    EG_DECAY   = 3'd2,
    EG_SUSTAIN = 3'd3,
    EG_RELEASE = 3'd4
  } eg_state_t;

endpackage

// File: rtl/fm_envelope_if.sv
// Control/result bundle between a voice controller and one envelope generator.
interface fm_envelope_if;
  import fm_pkg::*;

  logic               sample_tick;
  logic               key_on;
  logic [3:0]         attack_rate;
  logic [3:0]         decay_rate;
  logic [3:0]         sustain_level;
  logic [3:0]         release_rate;
  logic               sustain_hold;
  logic [5:0]         total_level;
  logic [ATTEN_W-1:0] atten;
  logic [2:0]         eg_state;
  logic               idle;

  modport master (
    output sample_tick, key_on, attack_rate, decay_rate, sustain_level,
           release_rate, sustain_hold, total_level,
    input  atten, eg_state, idle
  );

  modport slave (
    input  sample_tick, key_on, attack_rate, decay_rate, sustain_level,
           release_rate, sustain_hold, total_level,
    output atten, eg_state, idle
  );
endinterface

// File: rtl/fm_eg_rate.sv
// Rate decoder: step enable from the global rate counter and step size for one rate.
module fm_eg_rate #(
  parameter int unsigned EG_CNT_BITS = 15
) (
  input  logic [3:0]             rate,
  input  logic [EG_CNT_BITS-1:0] eg_cnt,
  output logic                   step_en,
  output logic [2:0]             inc
);

  logic [3:0]             shift;
  logic [EG_CNT_BITS-1:0] mask;

  always_comb begin
    shift   = 4'd15 - rate;
    // Low 'shift' bits set: rate r steps every 2^(15-r) ticks
    mask    = ~({EG_CNT_BITS{1'b1}} << shift);
    step_en = (rate != 4'd0) && ((eg_cnt & mask) == '0);
    if (rate == 4'd15)
      inc = 3'd4;
    else if (rate >= 4'd13)
      inc = 3'd2;
    else
      inc = 3'd1;
  end

endmodule

// File: rtl/fm_envelope.sv
// Per-operator ADSR envelope generator producing 12-bit log attenuation.
module fm_envelope
  import fm_pkg::*;
#(
  parameter int unsigned EG_CNT_BITS = 15
) (
  input logic         clk,
  input logic         reset,
  fm_envelope_if.slave bus
);

  logic [ENV_W-1:0]       env;
  eg_state_t              state;
  logic                   key_prev;
  logic [EG_CNT_BITS-1:0] eg_cnt;

  logic [3:0]       sel_rate;
  logic             step_en;
  logic [2:0]       inc;
  logic [ENV_W:0]   env_up;
  logic [ENV_W-1:0] env_up_sat;
  logic [ENV_W-1:0] atk_dec;
  logic [ENV_W-1:0] env_dn;
  logic [ENV_W-1:0] target;
  logic [ENV_W-1:0] rel_next;
  logic             key_rise;
  logic             key_fall;
  logic [12:0]      atten_sum;

  always_comb begin
    unique case (state)
      EG_ATTACK:             sel_rate = bus.attack_rate;
      EG_DECAY:              sel_rate = bus.decay_rate;
      EG_SUSTAIN, EG_RELEASE: sel_rate = bus.release_rate;
      default:               sel_rate = 4'd0;
    endcase
  end

  fm_eg_rate #(.EG_CNT_BITS(EG_CNT_BITS)) u_rate (
    .rate    (sel_rate),
    .eg_cnt  (eg_cnt),
    .step_en (step_en),
    .inc     (inc)
  );

  always_comb begin
    env_up     = {1'b0, env} + (ENV_W+1)'(inc);
    env_up_sat = env_up[ENV_W] ? ENV_MAX : env_up[ENV_W-1:0];
    atk_dec    = (env >> 3) + 9'd1;
    env_dn     = (env >= atk_dec) ? (env - atk_dec) : '0;
    target     = {bus.sustain_level, 5'b0};
    rel_next   = step_en ? env_up_sat : env;
    key_rise   = bus.key_on && !key_prev;
    key_fall   = !bus.key_on && key_prev;
    atten_sum  = {1'b0, env, 3'b0} + {2'b0, bus.total_level, 5'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      env      <= ENV_MAX;
      state    <= EG_IDLE;
      key_prev <= 1'b0;
      eg_cnt   <= '0;
    end else if (bus.sample_tick) begin
      eg_cnt   <= eg_cnt + EG_CNT_BITS'(1);
      key_prev <= bus.key_on;
      if (key_rise) begin
        state <= EG_ATTACK;
        if (bus.attack_rate == 4'd15)
          env <= '0;
      end else if (key_fall) begin
        state <= EG_RELEASE;
      end else begin
        unique case (state)
          EG_ATTACK: begin
            if (env == '0)
              state <= EG_DECAY;
            else if (step_en && bus.attack_rate != 4'd15)
              env <= env_dn;
          end
          EG_DECAY: begin
            if (env >= target) begin
              env   <= target;
              state <= EG_SUSTAIN;
            end else if (step_en) begin
              env <= env_up_sat;
            end
          end
          EG_SUSTAIN: begin
            if (!bus.sustain_hold && step_en)
              env <= env_up_sat;
          end
          EG_RELEASE: begin
            env <= rel_next;
            if (rel_next == ENV_MAX)
              state <= EG_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bus.atten <= ATTEN_MAX;
    else
      bus.atten <= atten_sum[12] ? ATTEN_MAX : atten_sum[ATTEN_W-1:0];
  end

  assign bus.eg_state = state;
  assign bus.idle     = (state == EG_IDLE);

endmodule
